ensemble_vote_tally: RTL and testbench
======================================

# ensemble_vote_tally

Parametrised majority-vote tally for the bin-ratio ensemble SNN. After all member networks finish a sample, it reads one inferred label per network from the label store. It votes only for enabled networks, then scans the scoreboard for the winning class. The winner is presented on a valid/ready handshake to the downstream result interface instead of as a one-cycle pulse.

## Interface
- NUM_NETS, 20, number of member networks (≥2)
- NUM_CLASSES, 18, number of output classes (≥2, ≤2^LABEL_W)
- LABEL_W, 5, label/class-index width
- MIN_MARGIN, 2, minimum winner-minus-runner-up margin; used only with ENSEMBLE_MARGIN_EN
- Derived localparams: NET_W = $clog2(NUM_NETS); CNT_W = $clog2(NUM_NETS+1)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- trans_start  in  1  start of a new sample; sampled only in IDLE
- all_nets_finished  in  1  all networks done; sampled only in WAIT_NETS
- net_enable  in  NUM_NETS  per-net vote mask; sampled on the TALLY cycle that issues each net's address
- label_rd_addr  out  NET_W  label-store read address (net index)
- label_rd_data  in  LABEL_W  label-store data, valid exactly 1 cycle after label_rd_addr
- ensemble_request  out  1  high while in IDLE
- busy  out  1  high in every state except IDLE
- winner_valid  out  1  result valid
- winner_ready  in  1  downstream accepts result
- winner_ID  out  LABEL_W  winning class
- winner_count  out  CNT_W  votes for the winning class
- label_err  out  1  sticky: an enabled net returned a label ≥ NUM_CLASSES; cleared only by rst or trans_start

## Operation
- States:
  - IDLE → WAIT_NETS on trans_start.
  - WAIT_NETS → TALLY on all_nets_finished.
  - TALLY → SCAN after NUM_NETS+1 cycles.
  - SCAN → OUTPUT after NUM_CLASSES cycles.
  - OUTPUT → IDLE on the edge where winner_valid && winner_ready.
- TALLY: label_rd_addr steps 0…NUM_NETS-1, one per cycle. An enable bit is registered with each address. On the following cycle, if that net's enable bit was set:
  - a label < NUM_CLASSES increments score[label];
  - any other label sets label_err and is not counted.
- Scoreboard: NUM_CLASSES entries of CNT_W bits; entries cannot overflow.
- SCAN: visits classes 0…NUM_CLASSES-1, one per cycle. If score > max, it updates max and the best index. Strict comparison means ties resolve to the lowest class index. Each visited entry is zeroed in the same cycle, so no separate clear state exists.
- OUTPUT: winner_ID and winner_count are registered and held stable while winner_valid=1 && !winner_ready.
- No enabled nets, or all labels invalid: winner_ID=0, winner_count=0.
- Ignored inputs:
  - trans_start outside IDLE.
  - all_nets_finished outside WAIT_NETS.
  - a net_enable change is ignored for nets whose addresses were already issued.
- label_rd_addr holds 0 outside TALLY.

## Timing
- Reset values: state=IDLE; ensemble_request=1; busy=0; winner_valid=0; winner_ID=0; winner_count=0; label_rd_addr=0; label_err=0; all scoreboard entries=0; all margin outputs=0.
- rst at any cycle, including mid-TALLY, mid-SCAN, or during OUTPUT: IDLE on the next edge with the scoreboard fully cleared. A result still held in OUTPUT is discarded.
- Latency: winner_valid rises NUM_NETS+NUM_CLASSES+1 cycles after the edge that samples all_nets_finished, which is 39 cycles at the defaults.
- winner_ready high in the first OUTPUT cycle: handshake completes at that edge, giving a one-cycle valid pulse.
- trans_start asserted in the same cycle the handshake completes: ignored, because the block is not yet in IDLE.
- Minimum sample-to-sample spacing: 2 + NUM_NETS+1 + NUM_CLASSES + 1 cycles.

## Configuration
- ENSEMBLE_MARGIN_EN defined:
  - Adds output runner_up_count (CNT_W) and output low_margin (1).
  - In SCAN: if score > max, second ← max and then max ← score. Otherwise, if score > second, second ← score. A tie with the max therefore gives margin 0.
  - low_margin = (winner_count − runner_up_count) < MIN_MARGIN. It is registered with the result and held during OUTPUT.
- ENSEMBLE_MARGIN_EN undefined:
  - runner_up_count and low_margin do not exist as ports.
  - No second-best register is built.
  - MIN_MARGIN is ignored.
  - All other behaviour is identical.

## Test plan
- Defaults, all 20 nets enabled and all vote 7 → winner_ID=7, winner_count=20, winner_valid 39 cycles after all_nets_finished; with the macro, runner_up_count=0 and low_margin=0.
- Nets 0–9 vote 12 and nets 10–19 vote 3 → winner_ID=3, winner_count=10; with the macro, runner_up_count=10 and low_margin=1.
- net_enable=20'h000FF, nets 0–7 vote 5 and nets 8–19 vote 9 → winner_ID=5, winner_count=8; net_enable=0 → winner_ID=0, winner_count=0.
- Net 4 returns label 20 and the rest vote 1 → winner_count=19, label_err=1 until the next trans_start.
- winner_ready held low for 10 cycles → outputs stable and winner_valid stays high. A second back-to-back sample where all nets vote 2 → winner_count=20 with no carry-over from the prior scoreboard.
- rst pulsed mid-TALLY, after net 6 → IDLE the next cycle; a fresh sample where all nets vote 0 gives winner_count=20.

Source files
------------

// File: rtl/ensemble_vote_tally.sv
// Majority-vote tally over NUM_NETS ensemble members with valid/ready result output.
// Optional macro ENSEMBLE_MARGIN_EN adds runner_up_count and low_margin outputs.
module ensemble_vote_tally #(
  parameter  int unsigned NUM_NETS    = 20,
  parameter  int unsigned NUM_CLASSES = 18,
  parameter  int unsigned LABEL_W     = 5,
  parameter  int unsigned MIN_MARGIN  = 2,
  localparam int unsigned NET_W       = $clog2(NUM_NETS),
  localparam int unsigned CNT_W       = $clog2(NUM_NETS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trans_start,
  input  logic               all_nets_finished,
  input  logic [NUM_NETS-1:0] net_enable,
  output logic [NET_W-1:0]   label_rd_addr,
  input  logic [LABEL_W-1:0] label_rd_data,
  output logic               ensemble_request,
  output logic               busy,
  output logic               winner_valid,
  input  logic               winner_ready,
  output logic [LABEL_W-1:0] winner_ID,
  output logic [CNT_W-1:0]   winner_count,
`ifdef ENSEMBLE_MARGIN_EN
  output logic [CNT_W-1:0]   runner_up_count,
  output logic               low_margin,
`endif
  output logic               label_err
);

  localparam logic [CNT_W-1:0]   LAST_T = CNT_W'(NUM_NETS);
  localparam logic [CNT_W-1:0]   LAST_A = CNT_W'(NUM_NETS - 1);
  localparam logic [LABEL_W-1:0] LAST_S = LABEL_W'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_TALLY, S_SCAN, S_OUT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   tcnt_q;
  logic [NET_W-1:0]   addr_q;
  logic               pend_q;
  logic [LABEL_W-1:0] scnt_q;
  logic [CNT_W-1:0]   score_q [NUM_CLASSES];
  logic [CNT_W-1:0]   max_q, max_d;
  logic [LABEL_W-1:0] best_q, best_d;
  logic [LABEL_W-1:0] win_id_q;
  logic [CNT_W-1:0]   win_cnt_q;
  logic               err_q;
  logic               label_ok;
  logic [CNT_W-1:0]   cur;
`ifdef ENSEMBLE_MARGIN_EN
  logic [CNT_W-1:0]   sec_q, sec_d;
  logic [CNT_W-1:0]   ru_q;
  logic               low_q;
`endif

  assign label_ok = (32'(label_rd_data) < NUM_CLASSES);
  assign cur      = score_q[scnt_q];

  always_comb begin
    max_d  = max_q;
    best_d = best_q;
`ifdef ENSEMBLE_MARGIN_EN
    sec_d  = sec_q;
`endif
    // Strict compare keeps the lowest class index on ties.
    if (cur > max_q) begin
`ifdef ENSEMBLE_MARGIN_EN
      sec_d  = max_q;
`endif
      max_d  = cur;
      best_d = scnt_q;
    end
`ifdef ENSEMBLE_MARGIN_EN
    else if (cur > sec_q) begin
      sec_d = cur;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      addr_q    <= '0;
      pend_q    <= 1'b0;
      scnt_q    <= '0;
      max_q     <= '0;
      best_q    <= '0;
      win_id_q  <= '0;
      win_cnt_q <= '0;
      err_q     <= 1'b0;
`ifdef ENSEMBLE_MARGIN_EN
      sec_q     <= '0;
      ru_q      <= '0;
      low_q     <= 1'b0;
`endif
      for (int unsigned i = 0; i < NUM_CLASSES; i++) score_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trans_start) begin
            state_q <= S_WAIT;
            err_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (all_nets_finished) begin
            state_q <= S_TALLY;
            tcnt_q  <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
          end
        end
        S_TALLY: begin
          // Enable is captured alongside the address; the vote lands when the data returns.
          pend_q <= (tcnt_q < LAST_T) && net_enable[addr_q];
          if (pend_q) begin
            if (label_ok) score_q[label_rd_data] <= score_q[label_rd_data] + 1'b1;
            else          err_q <= 1'b1;
          end
          if (tcnt_q == LAST_T) begin
            state_q <= S_SCAN;
            scnt_q  <= '0;
            max_q   <= '0;
            best_q  <= '0;
            addr_q  <= '0;
`ifdef ENSEMBLE_MARGIN_EN
            sec_q   <= '0;
`endif
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
            addr_q <= (tcnt_q >= LAST_A) ? '0 : addr_q + 1'b1;
          end
        end
        S_SCAN: begin
          score_q[scnt_q] <= '0;
          max_q  <= max_d;
          best_q <= best_d;
`ifdef ENSEMBLE_MARGIN_EN
          sec_q  <= sec_d;
`endif
          if (scnt_q == LAST_S) begin
            state_q   <= S_OUT;
            win_id_q  <= best_d;
            win_cnt_q <= max_d;
`ifdef ENSEMBLE_MARGIN_EN
            ru_q  <= sec_d;
            low_q <= (32'(max_d - sec_d) < MIN_MARGIN);
`endif
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
        S_OUT: begin
          if (winner_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign label_rd_addr    = addr_q;
  assign ensemble_request = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign winner_valid     = (state_q == S_OUT);
  assign winner_ID        = win_id_q;
  assign winner_count     = win_cnt_q;
  assign label_err        = err_q;
`ifdef ENSEMBLE_MARGIN_EN
  assign runner_up_count  = ru_q;
  assign low_margin       = low_q;
`endif

endmodule

// File: tb/tb_ensemble_vote_tally.sv
// Scoreboard bench for ensemble_vote_tally: directed samples, monitor compares on valid.
module tb_ensemble_vote_tally;
  localparam int NN  = 20;
  localparam int NC  = 18;
  localparam int LW  = 5;
  localparam int CW  = $clog2(NN + 1);
  localparam int NW  = $clog2(NN);
  localparam int LAT = NN + NC + 1;

  logic          clk = 1'b0;
  logic          rst, trans_start, all_nets_finished, winner_ready;
  logic [NN-1:0] net_enable;
  logic [NW-1:0] label_rd_addr;
  logic [LW-1:0] label_rd_data;
  logic          ensemble_request, busy, winner_valid, label_err;
  logic [LW-1:0] winner_ID;
  logic [CW-1:0] winner_count;
`ifdef ENSEMBLE_MARGIN_EN
  logic [CW-1:0] runner_up_count;
  logic          low_margin;
`endif

  ensemble_vote_tally #(.NUM_NETS(NN), .NUM_CLASSES(NC), .LABEL_W(LW), .MIN_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .trans_start(trans_start), .all_nets_finished(all_nets_finished),
    .net_enable(net_enable), .label_rd_addr(label_rd_addr), .label_rd_data(label_rd_data),
    .ensemble_request(ensemble_request), .busy(busy), .winner_valid(winner_valid),
    .winner_ready(winner_ready), .winner_ID(winner_ID), .winner_count(winner_count),
`ifdef ENSEMBLE_MARGIN_EN
    .runner_up_count(runner_up_count), .low_margin(low_margin),
`endif
    .label_err(label_err));

  always #5 clk = ~clk;

  logic [LW-1:0] mem [NN];
  always @(posedge clk) label_rd_data <= mem[label_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id; int cnt; int ru; int low; int err; int t0;
  } exp_t;
  exp_t q[$];

  int   total = 0;
  int   bad   = 0;
  int   last_err = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every cycle valid is high (checks stability too), pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (winner_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          chk("winner_ID", int'(winner_ID), q[0].id);
          chk("winner_count", int'(winner_count), q[0].cnt);
`ifdef ENSEMBLE_MARGIN_EN
          chk("runner_up_count", int'(runner_up_count), q[0].ru);
          chk("low_margin", int'(low_margin), q[0].low);
`endif
          if (!prev_valid) chk("latency", cyc - q[0].t0, LAT);
          if (winner_ready) begin
            chk("label_err", int'(label_err), q[0].err);
            void'(q.pop_front());
          end
        end
      end
      prev_valid = winner_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_range(input int lo, input int hi, input int val);
    for (int i = lo; i <= hi; i++) mem[i] = LW'(val);
  endtask

  task automatic run(input logic [NN-1:0] en, input int delay, input int id, input int cnt,
                     input int ru, input int low, input int err, input bit ts_hs);
    int n;
    n = 0;
    while (!ensemble_request && n < 200) begin tick(); n++; end
    if (!ensemble_request) chk("request_timeout", 0, 1);
    chk("err_hold", int'(label_err), last_err);
    net_enable  = en;
    trans_start = 1'b1;
    tick();
    trans_start = 1'b0;
    chk("busy_wait", int'(busy), 1);
    all_nets_finished = 1'b1;
    tick();
    all_nets_finished = 1'b0;
    q.push_back('{id, cnt, ru, low, err, cyc});
    winner_ready = (delay == 0);
    n = 0;
    while (!winner_valid && n < 100) begin tick(); n++; end
    if (!winner_valid) chk("valid_timeout", 0, 1);
    for (int i = 0; i < delay; i++) tick();
    winner_ready = 1'b1;
    trans_start  = ts_hs;
    tick();
    winner_ready = 1'b0;
    trans_start  = 1'b0;
    chk("valid_drop", int'(winner_valid), 0);
    chk("idle_after", int'(busy), 0);
    last_err = err;
  endtask

  initial begin
    rst = 1'b1; trans_start = 1'b0; all_nets_finished = 1'b0;
    winner_ready = 1'b0; net_enable = '0;
    set_range(0, NN - 1, 0);
    repeat (3) tick();
    chk("rst_request", int'(ensemble_request), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(winner_valid), 0);
    chk("rst_id", int'(winner_ID), 0);
    chk("rst_count", int'(winner_count), 0);
    chk("rst_addr", int'(label_rd_addr), 0);
    chk("rst_err", int'(label_err), 0);
    rst = 1'b0;
    tick();

    set_range(0, NN - 1, 7);
    run('1, 0, 7, 20, 0, 0, 0, 1'b0);

    set_range(0, 9, 12); set_range(10, 19, 3);
    run('1, 0, 3, 10, 10, 1, 0, 1'b0);

    set_range(0, 7, 5); set_range(8, 19, 9);
    run(20'h000FF, 0, 5, 8, 0, 0, 0, 1'b0);
    run('0, 0, 0, 0, 0, 1, 0, 1'b0);

    set_range(0, NN - 1, 1); mem[4] = LW'(20);
    run('1, 0, 1, 19, 0, 0, 1, 1'b0);

    set_range(0, 4, 17); set_range(5, 19, 0);
    run('1, 10, 0, 15, 5, 0, 0, 1'b0);

    set_range(0, NN - 1, 2);
    run('1, 0, 2, 20, 0, 0, 0, 1'b1);

    // Abort mid-TALLY after net 6's address, then a clean sample.
    set_range(0, NN - 1, 0);
    net_enable = '1;
    trans_start = 1'b1; tick(); trans_start = 1'b0;
    all_nets_finished = 1'b1; tick(); all_nets_finished = 1'b0;
    repeat (6) tick();
    chk("tally_addr6", int'(label_rd_addr), 6);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_request", int'(ensemble_request), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_addr", int'(label_rd_addr), 0);
    rst = 1'b0;
    last_err = 0;
    tick();
    run('1, 0, 0, 20, 0, 0, 0, 1'b0);

    repeat (5) tick();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
